motor_sensor_emulator: RTL and testbench

// Synthesizable N-channel emulator of BLDC hall sensors and quadrature encoders.

---
 rtl/motor_sensor_emulator_if.sv | 23 ++
 rtl/motor_sensor_emulator.sv | 155 +++++++++++++++
 tb/tb_motor_sensor_emulator.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/motor_sensor_emulator_if.sv
// Configuration write bus for the motor sensor emulator.
// Handshake: wr_en is a single-cycle valid strobe with an always-ready sink.
// Every cycle in which wr_en is high is one accepted write of the wr_* payload.
// There is no back-pressure, so the master never waits.
interface motor_sensor_emulator_if #(
  parameter int HALL_PER_W = 20,
  parameter int ENC_PER_W  = 12
);
  logic                  wr_en;
  logic [2:0]            wr_chan;
  logic [1:0]            wr_mode;
  logic                  wr_dir;
  logic [HALL_PER_W-1:0] wr_hall_per;
  logic [ENC_PER_W-1:0]  wr_enc_per;

  modport master (
    output wr_en, wr_chan, wr_mode, wr_dir, wr_hall_per, wr_enc_per
  );

  modport slave (
    input wr_en, wr_chan, wr_mode, wr_dir, wr_hall_per, wr_enc_per
  );
endinterface

// File: rtl/motor_sensor_emulator.sv
// N-channel emulator of BLDC hall sensors and quadrature encoders.
// Each channel holds a mode, a direction, and hall and encoder step periods.
// Every output line is driven from a flop, so no input reaches an output combinationally.
module motor_sensor_emulator #(
  parameter int NUM_MOTORS = 5,
  parameter int HALL_PER_W = 20,
  parameter int ENC_PER_W  = 12
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  motor_sensor_emulator_if.slave cfg,
  output logic [NUM_MOTORS-1:0] hall_a,
  output logic [NUM_MOTORS-1:0] hall_b,
  output logic [NUM_MOTORS-1:0] hall_c,
  output logic [NUM_MOTORS-1:0] enc_a,
  output logic [NUM_MOTORS-1:0] enc_b,
  output logic [NUM_MOTORS-1:0] hall_step
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_FAULT = 2'd1,
    MODE_RUN   = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  // Hall sequence, index 0..5 -> {a,b,c}.
  function automatic logic [2:0] hall_code(input logic [2:0] idx);
    case (idx)
      3'd0:    hall_code = 3'b101;
      3'd1:    hall_code = 3'b100;
      3'd2:    hall_code = 3'b110;
      3'd3:    hall_code = 3'b010;
      3'd4:    hall_code = 3'b011;
      3'd5:    hall_code = 3'b001;
      default: hall_code = 3'b101;
    endcase
  endfunction

  // Gray-coded quadrature sequence, state 0..3 -> {a,b}.
  function automatic logic [1:0] quad_code(input logic [1:0] st);
    case (st)
      2'd0:    quad_code = 2'b00;
      2'd1:    quad_code = 2'b01;
      2'd2:    quad_code = 2'b11;
      default: quad_code = 2'b10;
    endcase
  endfunction

  // Hall index moves modulo 6 in the selected direction.
  function automatic logic [2:0] next_hall(input logic [2:0] idx, input logic dir);
    if (dir) next_hall = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    else     next_hall = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  // Reset asserts asynchronously and releases on a clock edge after two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Reset release synchroniser
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_chan
    mode_e                 mode_q;
    logic                  dir_q;
    logic [HALL_PER_W-1:0] hall_per_q;
    logic [HALL_PER_W-1:0] hall_cnt_q;
    logic [ENC_PER_W-1:0]  enc_per_q;
    logic [ENC_PER_W-1:0]  enc_cnt_q;
    logic [2:0]            hall_idx_q;
    logic [1:0]            quad_q;
    logic [2:0]            hall_q;
    logic [1:0]            enc_q;
    logic                  step_q;
    logic                  wr_hit;
    logic                  run;
    logic                  hall_tc;
    logic                  enc_tc;

    assign wr_hit  = cfg.wr_en && (cfg.wr_chan == 3'(g));
    assign run     = (mode_q == MODE_RUN);
    // A zero period never reaches terminal count, which freezes that stream.
    assign hall_tc = run && (hall_per_q != '0) &&
                     (hall_cnt_q == hall_per_q - HALL_PER_W'(1));
    assign enc_tc  = run && (enc_per_q != '0) &&
                     (enc_cnt_q == enc_per_q - ENC_PER_W'(1));

    // Config latch, period counters and position stepping; a write beats a terminal count
    always_ff @(posedge sysclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        mode_q     <= MODE_OFF;
        dir_q      <= 1'b0;
        hall_per_q <= '0;
        hall_cnt_q <= '0;
        enc_per_q  <= '0;
        enc_cnt_q  <= '0;
        hall_idx_q <= 3'd0;
        quad_q     <= 2'd0;
        step_q     <= 1'b0;
      end else if (wr_hit) begin
        mode_q     <= mode_e'(cfg.wr_mode);
        dir_q      <= cfg.wr_dir;
        hall_per_q <= cfg.wr_hall_per;
        enc_per_q  <= cfg.wr_enc_per;
        hall_cnt_q <= '0;
        enc_cnt_q  <= '0;
        step_q     <= 1'b0;
      end else begin
        step_q <= hall_tc;
        if (hall_tc) begin
          hall_cnt_q <= '0;
          hall_idx_q <= next_hall(hall_idx_q, dir_q);
        end else if (run && (hall_per_q != '0)) begin
          hall_cnt_q <= hall_cnt_q + HALL_PER_W'(1);
        end
        if (enc_tc) begin
          enc_cnt_q <= '0;
          quad_q    <= dir_q ? quad_q - 2'd1 : quad_q + 2'd1;
        end else if (run && (enc_per_q != '0)) begin
          enc_cnt_q <= enc_cnt_q + ENC_PER_W'(1);
        end
      end
    end

    // Registered line drivers; OFF and FAULT leave the encoder lines where they were
    always_ff @(posedge sysclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        hall_q <= 3'b111;
        enc_q  <= 2'b00;
      end else begin
        case (mode_q)
          MODE_OFF:   hall_q <= 3'b111;
          MODE_FAULT: hall_q <= 3'b000;
          default: begin
            hall_q <= hall_code(hall_idx_q);
            enc_q  <= quad_code(quad_q);
          end
        endcase
      end
    end

    assign hall_a[g]    = hall_q[2];
    assign hall_b[g]    = hall_q[1];
    assign hall_c[g]    = hall_q[0];
    assign enc_a[g]     = enc_q[1];
    assign enc_b[g]     = enc_q[0];
    assign hall_step[g] = step_q;
  end

endmodule

// File: tb/tb_motor_sensor_emulator.sv
// Directed bench for motor_sensor_emulator with a queue-based scoreboard.
module tb_motor_sensor_emulator;
  localparam int NUM_MOTORS = 5;
  localparam int HALL_PER_W = 20;
  localparam int ENC_PER_W  = 12;
  localparam logic [31:0] RST_SNAP = {2'b00, 5'h00, 5'h00, 5'h00, 5'h1f, 5'h1f, 5'h1f};

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst_n;
  always #5 sysclk = ~sysclk;

  logic [NUM_MOTORS-1:0] hall_a, hall_b, hall_c, enc_a, enc_b, hall_step;

  motor_sensor_emulator_if #(.HALL_PER_W(HALL_PER_W), .ENC_PER_W(ENC_PER_W)) cfg ();

  motor_sensor_emulator #(
    .NUM_MOTORS(NUM_MOTORS),
    .HALL_PER_W(HALL_PER_W),
    .ENC_PER_W (ENC_PER_W)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .cfg      (cfg),
    .hall_a   (hall_a),
    .hall_b   (hall_b),
    .hall_c   (hall_c),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .hall_step(hall_step)
  );

  // ---------------- reference tables ----------------
  logic [2:0] hall_tbl [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [1:0] quad_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [2:0] halls(input int ch);
    return {hall_a[ch], hall_b[ch], hall_c[ch]};
  endfunction

  function automatic logic [31:0] snap();
    return {2'b00, hall_step, enc_a, enc_b, hall_a, hall_b, hall_c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cfg(input int ch, input int mode, input int dir, input int hp, input int ep);
    cfg.wr_chan     = 3'(ch);
    cfg.wr_mode     = 2'(mode);
    cfg.wr_dir      = 1'(dir);
    cfg.wr_hall_per = HALL_PER_W'(hp);
    cfg.wr_enc_per  = ENC_PER_W'(ep);
    cfg.wr_en       = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge following the write edge.
  task automatic write_cfg(input int ch, input int mode, input int dir, input int hp, input int ep);
    drive_cfg(ch, mode, dir, hp, ep);
    @(negedge sysclk);
    cfg.wr_en = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int steps [NUM_MOTORS];
    cfg.wr_en = 1'b0; cfg.wr_chan = 3'd0; cfg.wr_mode = 2'd0; cfg.wr_dir = 1'b0;
    cfg.wr_hall_per = '0; cfg.wr_enc_per = '0;
    rst_n = 1'b0;
    #12;
    exp_q.push_back(RST_SNAP);
    check("reset_state", snap());
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    // ch0 RUN forward, hall period 4
    write_cfg(0, 2, 0, 4, 0);
    for (int k = 0; k <= 28; k++) begin
      logic [2:0] h;
      logic s;
      if (k > 0) @(negedge sysclk);
      h = (k == 0) ? 3'b111 : hall_tbl[((k - 1) / 4) % 6];
      s = (k > 0) && (k % 4 == 0);
      exp_q.push_back({12'b0, 4'b0, s, 4'hf, h[2], 4'hf, h[1], 4'hf, h[0]});
      check("t2_ch0_run_p4", {12'b0, hall_step, hall_a, hall_b, hall_c});
    end

    // ch2 RUN reverse, encoder period 1, hall period 0
    write_cfg(2, 2, 1, 0, 1);
    for (int k = 0; k <= 8; k++) begin
      logic [2:0] h;
      logic [1:0] e;
      int st;
      if (k > 0) @(negedge sysclk);
      st = (k == 0) ? 0 : (4 - ((k - 1) % 4)) % 4;
      h  = (k == 0) ? 3'b111 : 3'b101;
      e  = (k == 0) ? 2'b00 : quad_tbl[st];
      exp_q.push_back({26'b0, 1'b0, h, e});
      check("t3_ch2_enc_rev", {26'b0, hall_step[2], halls(2), enc_a[2], enc_b[2]});
    end

    // ch1 RUN forward period 3 up to idx 2, then FAULT, OFF, RUN
    write_cfg(1, 2, 0, 3, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge sysclk);
      exp_q.push_back({28'b0, (k % 3 == 0), hall_tbl[(k - 1) / 3]});
      check("t4_ch1_run_p3", {28'b0, hall_step[1], halls(1)});
    end
    write_cfg(1, 1, 0, 3, 0);
    exp_q.push_back(32'b110);
    check("t4_ch1_idx2", {29'b0, halls(1)});
    @(negedge sysclk);
    exp_q.push_back(32'b000);
    check("t4_ch1_fault", {29'b0, halls(1)});
    write_cfg(1, 0, 0, 3, 0);
    exp_q.push_back(32'b000);
    check("t4_ch1_fault_hold", {29'b0, halls(1)});
    @(negedge sysclk);
    exp_q.push_back(32'b111);
    check("t4_ch1_off", {29'b0, halls(1)});
    write_cfg(1, 2, 0, 3, 0);
    for (int k = 0; k <= 4; k++) begin
      logic [2:0] h;
      if (k > 0) @(negedge sysclk);
      h = (k == 0) ? 3'b111 : ((k <= 3) ? 3'b110 : 3'b010);
      exp_q.push_back({28'b0, (k == 3), h});
      check("t4_ch1_resume", {28'b0, hall_step[1], halls(1)});
    end

    // ch3 rewritten on its terminal-count cycle, then a write to channel 7
    write_cfg(3, 2, 0, 4, 0);
    repeat (3) @(negedge sysclk);
    write_cfg(3, 2, 0, 4, 0);
    for (int k = 0; k <= 16; k++) begin
      logic [2:0] h;
      logic s;
      if (k > 0) @(negedge sysclk);
      h = (k == 0) ? hall_tbl[0] : hall_tbl[((k - 1) / 4) % 6];
      s = (k > 0) && (k % 4 == 0);
      exp_q.push_back({22'b0, s, h, 3'b111, 3'b101});
      check("t5_ch3_tc_write", {22'b0, hall_step[3], halls(3), halls(4), halls(2)});
      if (k == 8) drive_cfg(7, 1, 1, 1, 1);
      if (k == 9) cfg.wr_en = 1'b0;
    end

    // all channels RUN with periods 2..6 over 360 cycles each
    for (int c = 0; c < NUM_MOTORS; c++) steps[c] = 0;
    for (int j = -1; j <= 364; j++) begin
      int bad;
      @(negedge sysclk);
      if (j >= 0) begin
        bad = 0;
        for (int c = 0; c < NUM_MOTORS; c++) begin
          int d;
          d = j - c;
          if (d >= 1 && d <= 360) begin
            steps[c] += int'(hall_step[c]);
            if (halls(c) == 3'b000 || halls(c) == 3'b111) bad++;
          end
        end
        if (j >= 1) begin
          exp_q.push_back(32'd0);
          check("t6_hall_legal", 32'(bad));
        end
      end
      if (j + 1 <= 4) drive_cfg(j + 1, 2, 0, j + 3, 5);
      else            cfg.wr_en = 1'b0;
    end
    for (int c = 0; c < NUM_MOTORS; c++) begin
      exp_q.push_back(32'(360 / (c + 2)));
      check($sformatf("t6_steps_ch%0d", c), 32'(steps[c]));
    end

    // asynchronous reset in the middle of activity
    @(negedge sysclk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(RST_SNAP);
    check("t1_async_reset", snap());
    @(negedge sysclk);
    exp_q.push_back(RST_SNAP);
    check("t1_reset_held", snap());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
